approx_mult_pipe: RTL and testbench



---
 rtl/approx_mult_pipe.sv | 146 ++++++++++++++
 tb/tb_approx_mult_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: pipelined unsigned WIDTH x WIDTH multiplier with a per-transaction
// choice between the exact product and a column-truncated approximate product.
// Elastic valid/ready pipeline of STAGES registers; p comes straight from the last stage.
// Optional build macro APPROX_ERR_STAT_EN adds stat_clr/stat_cnt/stat_err error statistics.
module approx_mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int TRUNC  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
`ifdef APPROX_ERR_STAT_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_cnt,
    output logic [31:0]          stat_err
`endif
);

    localparam int PW = 2 * WIDTH;

    // Column keep-mask: approximate mode discards every partial-product bit below TRUNC.
    logic [PW-1:0] w_mask;
    // One partial-product row per multiplier bit of a, already masked to the kept columns.
    logic [PW-1:0] w_row [WIDTH];
    logic [PW-1:0] w_approx;
    logic [PW-1:0] w_exact;
    logic [PW-1:0] w_prod;
    logic [STAGES-1:0] w_load;

    // Stage registers: valid bit plus product (and, with statistics, mode and error).
    logic              r_valid [STAGES];
    logic [PW-1:0]     r_prod  [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_mask
            assign w_mask[gi] = (gi >= TRUNC);
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
            assign w_row[gi] = a[gi] ? ((PW'(b) << gi) & w_mask) : '0;
        end
    endgenerate

    // Sum the kept partial-product bits; each bit sits in its own column so masking then adding is exact.
    always_comb begin
        w_approx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_approx = w_approx + w_row[i];
        end
    end

    assign w_exact = PW'(a) * PW'(b);
    assign w_prod  = mode ? w_approx : w_exact;

    // Load enables ripple back from out_ready: a stage loads when empty or when it empties this cycle.
    always_comb begin
        logic v_go;
        w_load = '0;
        v_go   = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            w_load[s] = !r_valid[s] || v_go;
            v_go      = w_load[s];
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[STAGES-1];
    assign p         = r_prod[STAGES-1];

`ifdef APPROX_ERR_STAT_EN
    logic              r_mode [STAGES];
    logic [PW-1:0]     r_err  [STAGES];
    logic [31:0]       r_stat_cnt;
    logic [31:0]       r_stat_err;
    logic [32:0]       w_err_sum;
    logic              w_stat_upd;
    logic [PW-1:0]     w_err;

    assign w_err      = w_exact - w_approx;
    assign w_stat_upd = r_valid[STAGES-1] && out_ready && r_mode[STAGES-1];
    assign w_err_sum  = {1'b0, r_stat_err} + 33'(r_err[STAGES-1]);
    assign stat_cnt   = r_stat_cnt;
    assign stat_err   = r_stat_err;

    // Saturating statistics over approximate-mode output transfers; stat_clr wins over an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cnt <= '0;
            r_stat_err <= '0;
        end else if (stat_clr) begin
            r_stat_cnt <= '0;
            r_stat_err <= '0;
        end else if (w_stat_upd) begin
            if (r_stat_cnt != 32'hFFFF_FFFF) r_stat_cnt <= r_stat_cnt + 32'd1;
            r_stat_err <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
        end
    end
`endif

    // Advance the elastic pipeline; data only changes when a valid item moves in, so p holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_prod[s]  <= '0;
`ifdef APPROX_ERR_STAT_EN
                r_mode[s]  <= 1'b0;
                r_err[s]   <= '0;
`endif
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_prod[0] <= w_prod;
`ifdef APPROX_ERR_STAT_EN
                    r_mode[0] <= mode;
                    r_err[0]  <= w_err;
`endif
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= r_valid[s-1];
                    if (r_valid[s-1]) begin
                        r_prod[s] <= r_prod[s-1];
`ifdef APPROX_ERR_STAT_EN
                        r_mode[s] <= r_mode[s-1];
                        r_err[s]  <= r_err[s-1];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Testbench for approx_mult_pipe: randomized and directed stimulus checked against a
// bit-level arithmetic reference model through a scoreboard queue on every output transfer.
module tb_approx_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (WIDTH=8, STAGES=2, TRUNC=4)
    logic        in_valid, in_ready, mode, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] p;
    // WIDTH=4, TRUNC=0 instance
    logic        v4, rdy4, m4, ov4, or4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
`ifdef APPROX_ERR_STAT_EN
    logic        stat_clr;
    logic [31:0] stat_cnt, stat_err, s4_cnt, s4_err;
`endif

    approx_mult_pipe #(.WIDTH(8), .STAGES(2), .TRUNC(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .p(p)
`ifdef APPROX_ERR_STAT_EN
        , .stat_clr(stat_clr), .stat_cnt(stat_cnt), .stat_err(stat_err)
`endif
    );

    approx_mult_pipe #(.WIDTH(4), .STAGES(3), .TRUNC(0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .a(a4), .b(b4), .mode(m4), .out_valid(ov4), .out_ready(or4), .p(p4)
`ifdef APPROX_ERR_STAT_EN
        , .stat_clr(1'b0), .stat_cnt(s4_cnt), .stat_err(s4_err)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] log_q[$];
    int          out_cyc[$];
    logic [7:0]  exp4_q[$];
    int          n_out4 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Reference: sum of kept partial-product bits straight from the arithmetic definition.
    function automatic logic [31:0] ref_mul(input int unsigned x, input int unsigned y,
                                            input bit m, input int w, input int t);
        logic [31:0] s;
        if (!m) return 32'(x * y);
        s = 0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (x[i] && y[j] && (i + j >= t)) s += (32'd1 << (i + j));
        return s;
    endfunction

    always @(posedge clk) cyc++;
    always @(negedge rst_n) begin
        exp_q.delete();
        exp4_q.delete();
    end

    // Compare process for the default instance: check every output transfer, record every input transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out: got p=%0d with nothing outstanding, required no output", p);
                end else begin
                    chk("out_p", p, exp_q.pop_front());
                end
                log_q.push_back(p);
                out_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) exp_q.push_back(16'(ref_mul(a, b, mode, 8, 4)));
        end
    end

    // Compare process for the WIDTH=4 instance: truncation of zero columns must give a*b.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov4 && or4) begin
                if (exp4_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out4: got p=%0d with nothing outstanding, required no output", p4);
                end else begin
                    chk("w4_p", p4, exp4_q.pop_front());
                end
                n_out4++;
            end
            if (v4 && rdy4) exp4_q.push_back(8'(a4 * b4));
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic m, output int tries);
        bit done;
        a = x; b = y; mode = m; in_valid = 1'b1;
        tries = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            tries++;
            if (in_ready) begin
                @(posedge clk); #1;
                done = 1;
            end else if (tries > 100) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", tries);
                done = 1;
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, acc, s0, idx0;
        logic [15:0] hold;
        in_valid = 0; a = 0; b = 0; mode = 0; out_ready = 1;
        v4 = 0; a4 = 0; b4 = 0; m4 = 0; or4 = 1;
`ifdef APPROX_ERR_STAT_EN
        stat_clr = 0;
`endif
        #23 rst_n = 1;
        @(posedge clk); #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_p", p, 0);
        chk("reset_in_ready", in_ready, 1);

        // Directed test: latency of the first product, then literal values
        idx0 = log_q.size();
        send(8'd255, 8'd255, 1'b0, t);
        in_valid = 0;
        chk("lat_not_yet", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", out_valid, 1);
        chk("exact_255x255", p, 65025);
        send(8'd255, 8'd255, 1'b1, t);
        send(8'd3,   8'd3,   1'b1, t);
        send(8'd16,  8'd16,  1'b0, t);
        send(8'd16,  8'd16,  1'b1, t);
        in_valid = 0;
        wait_drain();
        chk("dir_count", log_q.size() - idx0, 5);
        chk("approx_255x255", log_q[idx0+1], 64976);
        chk("approx_3x3", log_q[idx0+2], 0);
        chk("exact_16x16", log_q[idx0+3], 256);
        chk("approx_16x16", log_q[idx0+4], 256);
`ifdef APPROX_ERR_STAT_EN
        chk("stat_cnt", stat_cnt, 3);
        chk("stat_err", stat_err, 58);
        stat_clr = 1;
        @(posedge clk); #1;
        stat_clr = 0;
        chk("stat_cnt_clr", stat_cnt, 0);
        chk("stat_err_clr", stat_err, 0);
`endif

        // Streaming: 20 random back-to-back transactions, mixed mode
        s0 = out_cyc.size();
        for (int k = 0; k < 20; k++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom), t);
            chk("stream_accept_first_try", t, 1);
        end
        in_valid = 0;
        wait_drain();
        chk("stream_count", out_cyc.size() - s0, 20);
        chk("stream_rate", out_cyc[s0+19] - out_cyc[s0], 19);

        // Backpressure: 4 offers with out_ready low, exactly STAGES accepted
        out_ready = 0;
        a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); in_valid = 1;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc++;
                @(posedge clk); #1;
                a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 0;
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        hold = p;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_p_stable", p, hold);
        chk("bp_valid_stable", out_valid, 1);
        out_ready = 1;
        wait_drain();

        // Reset mid-flight with two transactions in the pipe
        out_ready = 0;
        send(8'($urandom), 8'($urandom), 1'b0, t);
        send(8'($urandom), 8'($urandom), 1'b1, t);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 0);
        #3 rst_n = 1;
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        send(8'd200, 8'd100, 1'b0, t);
        in_valid = 0;
        wait_drain();
        chk("post_rst_result", log_q[log_q.size()-1], 20000);

        // WIDTH=4, TRUNC=0: every operand pair in approximate mode
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                int tt;
                a4 = 4'(x); b4 = 4'(y); m4 = 1; v4 = 1;
                tt = 0;
                do begin
                    @(negedge clk);
                    tt++;
                end while (!rdy4 && tt < 100);
                @(posedge clk); #1;
            end
        end
        v4 = 0;
        for (int k = 0; k < 50 && (exp4_q.size() != 0 || ov4); k++) begin
            @(posedge clk); #1;
        end
        chk("w4_count", n_out4, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
